// File: rtl/fa_4bits_accum.sv
// fa_4bits_accum: packet accumulator on a 4-bit ripple adder, counting its carry-outs
// to recover the exact packet total over a valid/ready result handshake.
module fa_4bits (
   input  logic [3:0] i0,
   input  logic [3:0] i1,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;
   genvar i;
   assign c[0] = cin;
   for (i = 0; i < 4; i++) begin : g_fa
      assign sum[i]   = i0[i] ^ i1[i] ^ c[i];
      assign c[i + 1] = (i0[i] & i1[i]) | (c[i] & (i0[i] ^ i1[i]));
   end
   assign cout = c[4];
endmodule

module fa_4bits_accum #(
   parameter int MAX_OPS = 8,
   parameter int CNT_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_sum,
   output logic [CNT_W-1:0]   out_carry,
   output logic [CNT_W+3:0]   out_total,
   output logic               out_trunc
);
   localparam logic ACC  = 1'b0;
   localparam logic HOLD = 1'b1;
   logic             state;
   logic [3:0]       acc, fa_sum;
   logic             fa_cout;
   logic [CNT_W-1:0] carry, op_cnt;
   logic             trunc, beat, at_max;
   fa_4bits u_fa (.i0(acc), .i1(in_data), .cin(1'b0), .sum(fa_sum), .cout(fa_cout));
   assign in_ready  = state == ACC;
   assign out_valid = state == HOLD;
   assign beat      = in_valid & in_ready;
   assign at_max    = op_cnt == CNT_W'(MAX_OPS - 1);
   assign out_sum   = acc;
   assign out_carry = carry;
   assign out_total = {carry, acc};
   assign out_trunc = trunc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ACC;
         acc    <= '0;
         carry  <= '0;
         op_cnt <= '0;
         trunc  <= 1'b0;
      end else if (beat) begin
         acc    <= fa_sum;
         carry  <= carry + CNT_W'(fa_cout);
         op_cnt <= op_cnt + 1'b1;
         if (in_last | at_max) begin
            state <= HOLD;
            trunc <= ~in_last;
         end
      end else if (out_valid & out_ready) begin
         state  <= ACC;
         acc    <= '0;
         carry  <= '0;
         op_cnt <= '0;
         trunc  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fa_4bits_accum.sv
// tb_fa_4bits_accum: scoreboard bench; expected packet totals are pushed as beats
// are driven and popped when the accumulator presents a result.
module tb_fa_4bits_accum;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [3:0] in_data = '0;
   logic       in_ready, out_valid, out_trunc;
   logic [3:0] out_sum;
   logic [2:0] out_carry;
   logic [6:0] out_total;
   typedef struct packed {logic [6:0] total; logic trunc;} exp_t;
   exp_t       sb[$];
   logic [6:0] m_total = '0;
   int         m_cnt = 0;
   int         tests = 0, fails = 0;

   fa_4bits_accum #(.MAX_OPS(8), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
      .out_total(out_total), .out_trunc(out_trunc)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [3:0] d, input logic l);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = l;
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
      m_total = m_total + 7'(d);
      m_cnt++;
      if (l || m_cnt == 8) begin
         sb.push_back('{total: m_total, trunc: !l});
         m_total = '0;
         m_cnt = 0;
      end
   endtask

   task automatic check_out(input string name);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!out_valid || sb.size() == 0) begin
         fails++;
         $display("FAIL %s timeout: out_valid=%b queued=%0d", name, out_valid, sb.size());
         return;
      end
      e = sb.pop_front();
      tests++;
      if (n !== 0) begin fails++; $display("FAIL %s latency: got %0d extra cycles, want 0", name, n); end
      tests++;
      if (out_sum !== e.total[3:0]) begin fails++; $display("FAIL %s sum: got %0d want %0d", name, out_sum, e.total[3:0]); end
      tests++;
      if (out_carry !== e.total[6:4]) begin fails++; $display("FAIL %s carry: got %0d want %0d", name, out_carry, e.total[6:4]); end
      tests++;
      if (out_total !== e.total) begin fails++; $display("FAIL %s total: got %0d want %0d", name, out_total, e.total); end
      tests++;
      if (out_trunc !== e.trunc) begin fails++; $display("FAIL %s trunc: got %b want %b", name, out_trunc, e.trunc); end
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL %s in_ready in HOLD: got %b want 0", name, in_ready); end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12 rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, out_trunc} !== 3'b010) begin fails++; $display("FAIL reset flags: got v/r/t=%b want 010", {out_valid, in_ready, out_trunc}); end
      tests++;
      if ({out_sum, out_carry, out_total} !== 14'd0) begin fails++; $display("FAIL reset data: got sum=%0d carry=%0d total=%0d want 0", out_sum, out_carry, out_total); end
   endtask

   task automatic test_basic();
      send(4'd8, 1'b1);
      check_out("single8");
      send(4'd8, 1'b0); send(4'd1, 1'b1);
      check_out("8+1");
      send(4'd11, 1'b0); send(4'd10, 1'b1);
      check_out("11+10");
      send(4'd15, 1'b0); send(4'd9, 1'b0); send(4'd14, 1'b0); send(4'd5, 1'b1);
      check_out("four_beats");
   endtask

   task automatic test_max_ops();
      for (int i = 0; i < 8; i++) send(4'd15, 1'b0);
      check_out("force_close");
      for (int i = 0; i < 8; i++) send(4'd15, i == 7);
      check_out("last_on_eighth");
      for (int i = 0; i < 8; i++) send(4'(i + 1), 1'b0);
      check_out("ramp_force");
   endtask

   task automatic test_idle();
      send(4'd3, 1'b0);
      repeat (3) @(negedge clk);
      send(4'd4, 1'b1);
      check_out("idle_gap");
   endtask

   task automatic test_backpressure();
      int n = 0;
      send(4'd9, 1'b0); send(4'd9, 1'b1);
      @(negedge clk);
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      in_valid = 1'b1; in_data = 4'd15; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_total !== 7'd18) begin
            fails++;
            $display("FAIL stall%0d: got v=%b r=%b total=%0d want v=1 r=0 total=18", i, out_valid, in_ready, out_total);
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      void'(sb.pop_front());
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_total !== 7'd0) begin
         fails++;
         $display("FAIL release: got v=%b r=%b total=%0d want v=0 r=1 total=0", out_valid, in_ready, out_total);
      end
      send(4'd6, 1'b0); send(4'd3, 1'b1);
      check_out("after_release");
   endtask

   task automatic test_async_reset();
      send(4'd14, 1'b0); send(4'd5, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_total !== 7'd0) begin fails++; $display("FAIL midpkt_reset: got v=%b total=%0d want v=0 total=0", out_valid, out_total); end
      sb.delete(); m_total = '0; m_cnt = 0;
      @(negedge clk) rst_n = 1'b1;
      send(4'd6, 1'b0); send(4'd3, 1'b1);
      check_out("post_reset");
      send(4'd7, 1'b1);
      #2;
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_before_reset: got v=%b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_total !== 7'd0) begin fails++; $display("FAIL hold_reset: got v=%b total=%0d want v=0 total=0", out_valid, out_total); end
      sb.delete(); m_total = '0; m_cnt = 0;
      @(negedge clk) rst_n = 1'b1;
      send(4'd2, 1'b0); send(4'd2, 1'b1);
      check_out("post_hold_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_ops();
      test_idle();
      test_backpressure();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
